my_serial_subtractor: RTL and testbench

// - Bit-serial WIDTH-bit subtractor, D = A - B; the inverse operation to our ripple adders.
// - Reuses one full-adder slice over WIDTH clocks: A + ~B + 1, LSB first, with a carry flop.
// - Sits beside the combinational adders on the datapath where area matters more than latency.
// - Driven by a start/busy/done handshake from the control FSM.
//

---
 rtl/my_serial_subtractor.sv | 133 +++++++++++++
 tb/tb_my_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/my_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (D = A - B) built from one full-adder slice, LSB first.
// Define MY_SERIAL_SUB_ADD_MODE_EN to add a `sub` port that also selects addition.
module my_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             start,
`ifdef MY_SERIAL_SUB_ADD_MODE_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] a_shr, b_shr;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             bo_reg, bo_next;
  logic             sub_reg, sub_next;
  logic             sub_mode;
  logic             sum_bit;
  logic             carry_out;

`ifdef MY_SERIAL_SUB_ADD_MODE_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b1;
`endif

  // Single full-adder slice working on the current LSBs.
  assign sum_bit   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign carry_out = (a_sh_reg[0] & b_sh_reg[0]) |
                     (a_sh_reg[0] & carry_reg)   |
                     (b_sh_reg[0] & carry_reg);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
      assign a_shr[gi] = a_sh_reg[gi+1];
      assign b_shr[gi] = b_sh_reg[gi+1];
    end
  endgenerate
  assign a_shr[WIDTH-1] = 1'b0;
  assign b_shr[WIDTH-1] = 1'b0;

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    bo_next    = bo_reg;
    sub_next   = sub_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          a_sh_next  = A;
          b_sh_next  = sub_mode ? ~B : B;
          carry_next = sub_mode;
          sub_next   = sub_mode;
          cnt_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        d_next     = {sum_bit, d_reg[WIDTH-1:1]};
        a_sh_next  = a_shr;
        b_sh_next  = b_shr;
        carry_next = carry_out;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          // Subtract reports borrow as the inverted final carry; add reports it raw.
          bo_next    = sub_reg ? ~carry_out : carry_out;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      bo_reg    <= 1'b0;
      sub_reg   <= 1'b0;
    end else begin
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      bo_reg    <= bo_next;
      sub_reg   <= sub_next;
    end
  end

  assign busy = (state_reg == S_RUN);
  assign done = (state_reg == S_DONE);
  assign D    = d_reg;
  assign Bo   = bo_reg;

endmodule

// File: tb/tb_my_serial_subtractor.sv
// Self-checking bench for my_serial_subtractor (WIDTH=8): directed and random operations
// compared against an arithmetic reference; covers MY_SERIAL_SUB_ADD_MODE_EN when defined.
module tb_my_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_p;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, Bo;
  logic [W-1:0] D;
`ifdef MY_SERIAL_SUB_ADD_MODE_EN
  logic         sub;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  my_serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .start  (start),
`ifdef MY_SERIAL_SUB_ADD_MODE_EN
    .sub    (sub),
`endif
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .D      (D),
    .Bo     (Bo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    int unsigned r;
    if (s) begin
      r = (a + 256 - b) % 256;
      return {(a < b), W'(r)};
    end
    r = a + b;
    return {(r > 255), W'(r % 256)};
  endfunction

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    A     = a;
    B     = b;
`ifdef MY_SERIAL_SUB_ADD_MODE_EN
    sub   = s;
`endif
    start = 1'b1;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic [W:0] exp;
    int busy_cnt;
    bit got;
    exp = model(a, b, s);
    @(negedge clk);
    drive_start(a, b, s);
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, ".D"}, 32'(D), 32'(exp[W-1:0]));
    check({tag, ".Bo"}, 32'(Bo), 32'(exp[W]));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".D_hold"}, 32'(D), 32'(exp[W-1:0]));
    check({tag, ".Bo_hold"}, 32'(Bo), 32'(exp[W]));
    $display("op %s: A=%02h B=%02h s=%0d -> D=%02h Bo=%0d", tag, a, b, s, D, Bo);
  endtask

  initial begin
    logic [W:0] exp;
    int done_cnt;
    int last_done;
    int dones_seen;
    bit s;
    logic [W-1:0] ra, rb;

    reset_p = 1'b1;
    start   = 1'b0;
    A       = '0;
    B       = '0;
`ifdef MY_SERIAL_SUB_ADD_MODE_EN
    sub     = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.D", 32'(D), 32'd0);
    check("reset.Bo", 32'(Bo), 32'd0);
    reset_p = 1'b0;

    do_op("5-3", 8'h05, 8'h03, 1'b1);
    do_op("3-5", 8'h03, 8'h05, 1'b1);
    do_op("00-FF", 8'h00, 8'hFF, 1'b1);
    do_op("80-80", 8'h80, 8'h80, 1'b1);

    // Start pulsed during RUN must be ignored.
    exp = model(8'h21, 8'h0F, 1'b1);
    @(negedge clk);
    drive_start(8'h21, 8'h0F, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    drive_start(8'h44, 8'h99, 1'b1);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        done_cnt++;
        check("ignore.D", 32'(D), 32'(exp[W-1:0]));
        check("ignore.Bo", 32'(Bo), 32'(exp[W]));
      end
      @(negedge clk);
    end
    check("ignore.done_count", 32'(done_cnt), 32'd1);
    $display("op ignore: first operands 21-0F, done pulses=%0d", done_cnt);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    drive_start(8'hC3, 8'h3C, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_p = 1'b1;
    #1;
    check("areset.busy", 32'(busy), 32'd0);
    check("areset.done", 32'(done), 32'd0);
    check("areset.D", 32'(D), 32'd0);
    check("areset.Bo", 32'(Bo), 32'd0);
    @(negedge clk);
    reset_p = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("areset.no_done", 32'(done_cnt), 32'd0);
    $display("op areset: outputs cleared, spurious done pulses=%0d", done_cnt);
    do_op("after_reset", 8'hC3, 8'h3C, 1'b1);

    // Continuous start: back-to-back ops every W+2 cycles.
    exp = model(8'h10, 8'h01, 1'b1);
    @(negedge clk);
    drive_start(8'h10, 8'h01, 1'b1);
    last_done = -1;
    dones_seen = 0;
    for (int i = 0; i < 5 * (W + 2) && dones_seen < 3; i++) begin
      @(negedge clk);
      if (done) begin
        check("cont.D", 32'(D), 32'(exp[W-1:0]));
        check("cont.Bo", 32'(Bo), 32'(exp[W]));
        if (last_done >= 0) check("cont.period", 32'(cyc - last_done), 32'(W + 2));
        $display("op cont: done at cycle %0d D=%02h Bo=%0d", cyc, D, Bo);
        last_done = cyc;
        dones_seen++;
      end
    end
    start = 1'b0;
    check("cont.done_count", 32'(dones_seen), 32'd3);
    repeat (W + 4) @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef MY_SERIAL_SUB_ADD_MODE_EN
      s = 1'($urandom);
`else
      s = 1'b1;
`endif
      do_op($sformatf("rand%0d", n), ra, rb, s);
    end

`ifdef MY_SERIAL_SUB_ADD_MODE_EN
    do_op("add_FF+01", 8'hFF, 8'h01, 1'b0);
    do_op("sub_01-02", 8'h01, 8'h02, 1'b1);
    do_op("add_12+34", 8'h12, 8'h34, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
